// File: rtl/controlador_operaciones_alu.sv
// Command sequencer for an external ALU: latches a command, captures the ALU
// result one edge later and holds it until the consumer takes it.
module controlador_operaciones_alu #(
    parameter int ancho = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             comandoValido,
    output logic             comandoListo,
    input  logic [ancho:0]   comandoA,
    input  logic [ancho:0]   comandoB,
    input  logic [3:0]       comandoSeleccion,
    output logic [ancho:0]   aluOperandoA,
    output logic [ancho:0]   aluOperandoB,
    output logic [3:0]       aluSeleccion,
    input  logic [ancho:0]   aluResultado,
    input  logic             aluN,
    input  logic             aluZ,
    input  logic             aluC,
    input  logic             aluV,
    output logic             resultadoValido,
    input  logic             resultadoListo,
    output logic [ancho:0]   resultado,
    output logic [3:0]       banderas,
    output logic             error,
    output logic [7:0]       contadorOperaciones
);

    localparam logic [3:0] OP_DIVISION = 4'd3;
    localparam logic [3:0] OP_MODULO   = 4'd4;
    localparam logic [3:0] OP_ULTIMO   = 4'd9;

    typedef enum logic [1:0] {INACTIVO, OPERANDO, ENTREGA} estado_t;

    estado_t estado, estadoSig;
    logic    aceptar;
    logic    entregar;
    logic    comandoIlegal;
    logic    ilegalReg;

    assign aceptar  = comandoValido && (estado == INACTIVO);
    assign entregar = resultadoListo && (estado == ENTREGA);

    // Division and modulo by zero are rejected up front so the ALU never sees them as legal.
    always_comb begin
        comandoIlegal = 1'b0;
        if (comandoSeleccion > OP_ULTIMO)
            comandoIlegal = 1'b1;
        else if ((comandoSeleccion == OP_DIVISION || comandoSeleccion == OP_MODULO) &&
                 (comandoB == '0))
            comandoIlegal = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= INACTIVO;
        else     estado <= estadoSig;
    end

    always_comb begin
        estadoSig = estado;
        case (estado)
            INACTIVO: if (comandoValido)  estadoSig = OPERANDO;
            OPERANDO:                     estadoSig = ENTREGA;
            ENTREGA:  if (resultadoListo) estadoSig = INACTIVO;
            default:                      estadoSig = INACTIVO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluOperandoA <= '0;
            aluOperandoB <= '0;
            aluSeleccion <= '0;
            ilegalReg    <= 1'b0;
        end else if (aceptar) begin
            aluOperandoA <= comandoA;
            aluOperandoB <= comandoB;
            aluSeleccion <= comandoSeleccion;
            ilegalReg    <= comandoIlegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resultado <= '0;
            banderas  <= '0;
            error     <= 1'b0;
        end else if (estado == OPERANDO) begin
            if (ilegalReg) begin
                resultado <= '0;
                banderas  <= '0;
                error     <= 1'b1;
            end else begin
                resultado <= aluResultado;
                banderas  <= {aluN, aluZ, aluC, aluV};
                error     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           contadorOperaciones <= '0;
        else if (entregar) contadorOperaciones <= contadorOperaciones + 8'd1;
    end

    assign comandoListo    = (estado == INACTIVO);
    assign resultadoValido = (estado == ENTREGA);

endmodule

// File: tb/tb_controlador_operaciones_alu.sv
// Randomized bench with a transaction-level model of the sequencer plus a few
// hand-computed scenario checks.
module tb_controlador_operaciones_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       comandoValido;
    logic       comandoListo;
    logic [3:0] comandoA, comandoB, comandoSeleccion;
    logic [3:0] aluOperandoA, aluOperandoB, aluSeleccion;
    logic [3:0] aluResultado;
    logic       aluN, aluZ, aluC, aluV;
    logic       resultadoValido;
    logic       resultadoListo;
    logic [3:0] resultado;
    logic [3:0] banderas;
    logic       error;
    logic [7:0] contadorOperaciones;

    int checks = 0;
    int errors = 0;

    // ALU stub: either a real 4-bit ALU fed from the DUT's operand registers, or fixed values.
    logic       stubFijo = 1'b0;
    logic [3:0] stubRes  = '0;
    logic [3:0] stubFlg  = '0;
    logic [7:0] aluSalida;

    controlador_operaciones_alu #(.ancho(3)) dut (
        .clk(clk), .rst(rst),
        .comandoValido(comandoValido), .comandoListo(comandoListo),
        .comandoA(comandoA), .comandoB(comandoB), .comandoSeleccion(comandoSeleccion),
        .aluOperandoA(aluOperandoA), .aluOperandoB(aluOperandoB), .aluSeleccion(aluSeleccion),
        .aluResultado(aluResultado), .aluN(aluN), .aluZ(aluZ), .aluC(aluC), .aluV(aluV),
        .resultadoValido(resultadoValido), .resultadoListo(resultadoListo),
        .resultado(resultado), .banderas(banderas), .error(error),
        .contadorOperaciones(contadorOperaciones)
    );

    always #5 clk = ~clk;

    // Returns {N,Z,C,V, result}
    function automatic logic [7:0] aluFn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
        int r;
        logic c, v;
        logic [3:0] q;
        c = 1'b0; v = 1'b0; r = 0;
        case (s)
            4'd0: begin r = a + b; c = (r > 15); end
            4'd1: begin r = a - b; c = (a < b); end
            4'd2: begin r = a * b; c = (r > 15); end
            4'd3: r = (b == 0) ? 0 : a / b;
            4'd4: r = (b == 0) ? 0 : a % b;
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: begin r = a << 1; c = a[3]; end
            4'd9: begin r = a >> 1; c = a[0]; end
            default: r = 0;
        endcase
        q = r[3:0];
        if (s == 4'd0) v = (a[3] == b[3]) && (q[3] != a[3]);
        if (s == 4'd1) v = (a[3] != b[3]) && (q[3] != a[3]);
        return {q[3], (q == 4'd0), c, v, q};
    endfunction

    always_comb begin
        aluSalida = stubFijo ? {stubFlg, stubRes} : aluFn(aluOperandoA, aluOperandoB, aluSeleccion);
        aluResultado = aluSalida[3:0];
        {aluN, aluZ, aluC, aluV} = aluSalida[7:4];
    end

    // Model: where the current command is in its life (0 idle, 1 being computed,
    // 2 waiting for the consumer), plus the values the outputs must show.
    int         mFase;
    logic [3:0] mA, mB, mSel, mRes, mFlg;
    logic       mErr;
    int         mCnt;
    int         mTotal;

    task automatic modeloReset();
        mFase = 0; mA = 0; mB = 0; mSel = 0; mRes = 0; mFlg = 0; mErr = 0; mCnt = 0;
    endtask

    task automatic modeloFlanco();
        logic [7:0] x;
        if (rst) begin
            modeloReset();
        end else if (mFase == 0) begin
            if (comandoValido) begin
                mA = comandoA; mB = comandoB; mSel = comandoSeleccion; mFase = 1;
            end
        end else if (mFase == 1) begin
            if (mSel > 9 || ((mSel == 3 || mSel == 4) && mB == 0)) begin
                mRes = 0; mFlg = 0; mErr = 1;
            end else begin
                x = stubFijo ? {stubFlg, stubRes} : aluFn(mA, mB, mSel);
                mRes = x[3:0]; mFlg = x[7:4]; mErr = 0;
            end
            mFase = 2;
        end else if (resultadoListo) begin
            mFase = 0;
            mCnt = (mCnt + 1) % 256;
            mTotal++;
        end
    endtask

    task automatic chk(input string nombre, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, act, exp, $time);
        end
    endtask

    task automatic comparar();
        chk("comandoListo", comandoListo, (mFase == 0));
        chk("resultadoValido", resultadoValido, (mFase == 2));
        chk("aluOperandoA", aluOperandoA, mA);
        chk("aluOperandoB", aluOperandoB, mB);
        chk("aluSeleccion", aluSeleccion, mSel);
        chk("resultado", resultado, mRes);
        chk("banderas", banderas, mFlg);
        chk("error", error, mErr);
        chk("contador", contadorOperaciones, mCnt);
    endtask

    // Called just after a falling edge: drive, take one rising edge, update model, compare.
    task automatic paso(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] s, input logic listo);
        comandoValido = v; comandoA = a; comandoB = b; comandoSeleccion = s; resultadoListo = listo;
        @(posedge clk); #1;
        modeloFlanco();
        @(negedge clk);
        comparar();
    endtask

    task automatic pasoAleatorio();
        logic [3:0] b;
        b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
        paso($urandom_range(0, 1) == 1, 4'($urandom), b, 4'($urandom_range(0, 15)),
             $urandom_range(0, 2) != 0);
    endtask

    int cnt0;

    initial begin
        rst = 1'b1;
        comandoValido = 0; comandoA = 0; comandoB = 0; comandoSeleccion = 0; resultadoListo = 0;
        modeloReset();
        mTotal = 0;
        @(negedge clk);
        comparar();
        @(negedge clk);
        rst = 1'b0;
        paso(0, 0, 0, 0, 0);
        chk("listoTrasReset", comandoListo, 1);

        // Scenario A: fixed stub 8 / N=1
        stubFijo = 1; stubRes = 4'h8; stubFlg = 4'b1000;
        paso(1, 4'd5, 4'd3, 4'd0, 0);
        chk("A_opA", aluOperandoA, 5);
        chk("A_opB", aluOperandoB, 3);
        chk("A_sel", aluSeleccion, 0);
        paso(0, 0, 0, 0, 0);
        chk("A_valido", resultadoValido, 1);
        chk("A_res", resultado, 8);
        chk("A_flg", banderas, 4'b1000);
        chk("A_err", error, 0);
        paso(0, 0, 0, 0, 1);
        chk("A_cnt", contadorOperaciones, 1);

        // Scenario B: division by zero, then opcode 12
        stubRes = 4'hF; stubFlg = 4'hF;
        for (int k = 0; k < 2; k++) begin
            paso(1, 4'd7, 4'd0, (k == 0) ? 4'd3 : 4'd12, 0);
            paso(0, 0, 0, 0, 0);
            chk("B_res", resultado, 0);
            chk("B_flg", banderas, 0);
            chk("B_err", error, 1);
            paso(0, 0, 0, 0, 1);
        end
        stubFijo = 0;

        // Scenario C: backpressure with spurious commands
        paso(1, 4'd9, 4'd6, 4'd1, 0);
        paso(0, 0, 0, 0, 0);
        cnt0 = contadorOperaciones;
        for (int k = 0; k < 10; k++) paso(1, 4'($urandom), 4'($urandom), 4'($urandom), 0);
        chk("C_listo", comandoListo, 0);
        chk("C_cnt", contadorOperaciones, cnt0);
        chk("C_res", resultado, 4'd3);
        paso(1, 4'd1, 4'd1, 4'd0, 1);
        chk("C_cntMas1", contadorOperaciones, cnt0 + 1);
        chk("C_inactivo", comandoListo, 1);

        // Scenario D: random traffic up to 256 completions, counter wraps to 0
        while (mTotal < 256) pasoAleatorio();
        chk("D_wrap", contadorOperaciones, 0);

        // Scenario E: reset while operating
        paso(0, 0, 0, 0, 0);
        if (comandoListo !== 1'b1) chk("E_pre", comandoListo, 1);
        paso(1, 4'd4, 4'd2, 4'd2, 0);
        #2 rst = 1'b1;
        #1;
        chk("E_opA", aluOperandoA, 0);
        chk("E_sel", aluSeleccion, 0);
        chk("E_valido", resultadoValido, 0);
        chk("E_res", resultado, 0);
        chk("E_cnt", contadorOperaciones, 0);
        modeloReset();
        @(negedge clk);
        comparar();
        rst = 1'b0;
        paso(0, 0, 0, 0, 1);
        chk("E_listo", comandoListo, 1);
        chk("E_noValido", resultadoValido, 0);

        for (int k = 0; k < 200; k++) pasoAleatorio();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
